ififo: RTL and testbench
========================

IFIFO -- requirements
Module: ififo

Interface
REQ-001 Parameter P_DEPTH, default 16, entry count; power of two, 4..32.
REQ-002 Parameter P_AFULL, default 12, almost-full threshold in entries.
REQ-003 I_IFIFO_HCLK  in  1  sole clock; all state on rising edge.
REQ-004 I_IFIFO_HRESET  in  1  reset; synchronous, active-high.
REQ-005 I_IFIFO_HRDATA  in  32  AHB read data, driven by the AHB master interface RDATA output.
REQ-006 I_IFIFO_HADDR  in  32  address-phase address from the AHB master.
REQ-007 I_IFIFO_HTRANS  in  2  address-phase transfer type.
REQ-008 I_IFIFO_HSIZE  in  3  address-phase size: 000 byte, 001 half, 010 word.
REQ-009 I_IFIFO_HWRITE  in  1  address-phase direction; 1 = write.
REQ-010 I_IFIFO_HREADY  in  1  bus ready from slave.
REQ-011 I_IFIFO_CLEAR  in  1  synchronous flush from core.
REQ-012 I_IFIFO_POP  in  1  core consumes head entry.
REQ-013 O_IFIFO_DATA  out  32  head entry, first-word-fall-through.
REQ-014 O_IFIFO_EMPTY / O_IFIFO_FULL / O_IFIFO_AFULL  out  1 each  status flags.
REQ-015 O_IFIFO_COUNT  out  6  occupancy, 0..P_DEPTH.
REQ-016 O_IFIFO_OVERFLOW  out  1  sticky dropped-data flag.

Function
REQ-017 Address-phase acceptance: on an edge with HREADY=1, dphase_vld <= HTRANS[1] & ~HWRITE; dphase_lane <= HADDR[1:0]; dphase_size <= HSIZE.
REQ-018 While HREADY=0, dphase_vld, dphase_lane and dphase_size SHALL hold.
REQ-019 Push condition SHALL be dphase_vld & HREADY; exactly one entry per completed read data phase; IDLE/BUSY and write transfers never push.
REQ-020 Lane extraction: size 000 -> HRDATA byte selected by lane, zero-extended; size 001 -> half selected by lane[1], zero-extended; size 010 or any other code -> full word.
REQ-021 Pushed entry SHALL appear on O_IFIFO_DATA, with EMPTY=0, in the cycle after the push edge (1-cycle latency).
REQ-022 O_IFIFO_DATA SHALL equal the oldest entry when EMPTY=0 and 32'h0 when EMPTY=1.
REQ-023 POP with EMPTY=0 SHALL advance the read pointer; POP with EMPTY=1 SHALL be ignored.
REQ-024 Push and pop in the same cycle while not empty: both take effect, count unchanged.
REQ-025 Push and pop in the same cycle while empty: push accepted, pop ignored, count becomes 1.
REQ-026 Push with FULL=1 and no pop: data dropped, count unchanged, OVERFLOW <= 1.
REQ-027 Push with FULL=1 and a concurrent pop: push accepted, no overflow.
REQ-028 Pointers SHALL be log2(P_DEPTH) bits and wrap modulo P_DEPTH; the count register alone distinguishes full from empty.
REQ-029 EMPTY = (count==0); FULL = (count==P_DEPTH); AFULL = (count>=P_AFULL); all registered-consistent with COUNT in the same cycle.
REQ-030 OVERFLOW SHALL stay set until HRESET or CLEAR.
REQ-031 CLEAR SHALL zero pointers, count, OVERFLOW and dphase_vld; it overrides push and pop in the same cycle.

Reset
REQ-032 HRESET=1 at an edge: pointers 0, count 0, dphase_vld 0, OVERFLOW 0.
REQ-033 After reset: EMPTY=1, FULL=0, AFULL=0, COUNT=0, DATA=32'h0.
REQ-034 Reset mid-burst SHALL discard the pending data phase and all stored entries; storage array contents need no reset.

Structure
REQ-035 HTRANS codes (IDLE 00, BUSY 01, NSEQ 10, SEQ 11) and HSIZE codes SHALL live in the shared AHB definitions include, also used by the AHB master interface.
REQ-036 Storage SHALL be a sub-module ififo_mem: P_DEPTH x 32 register array, one synchronous write port and one asynchronous read port.
REQ-037 Control, lane extraction and flags SHALL reside in ififo; no other sub-modules.

Verification
REQ-038 INCR4 word reads at 0x100, HREADY=1, data A0..A3 -> four pushes; COUNT=4; pops return A0..A3 in order.
REQ-039 Byte read at 0x103, HRDATA=0xDDCCBBAA -> entry 0x000000DD; half read at 0x102 -> entry 0x0000DDCC.
REQ-040 Read data phase with HREADY=0 for 3 cycles -> no push until HREADY=1, then exactly one entry.
REQ-041 Fill 16 entries, push a 17th without pop -> FULL=1, COUNT=16, OVERFLOW=1, head unchanged; repeat with concurrent pop -> no overflow.
REQ-042 Empty FIFO, simultaneous push 0x5A5A5A5A and pop -> COUNT=1, DATA=0x5A5A5A5A next cycle.
REQ-043 COUNT=7 with CLEAR and push in the same cycle -> COUNT=0, EMPTY=1, OVERFLOW=0; HRESET mid-burst -> same result.

Source files
------------

// File: rtl/ififo_pkg.sv
// rtl/ififo_pkg.sv - shared AHB transfer/size codes used by the ififo and the AHB master interface
package ififo_pkg;

   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic [1:0] HTRANS_BUSY = 2'b01;
   localparam logic [1:0] HTRANS_NSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ  = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ififo_if.sv
// rtl/ififo_if.sv - AHB snoop and core-side signal bundle of the ififo
interface ififo_if;

   logic [31:0] I_IFIFO_HRDATA;
   logic [31:0] I_IFIFO_HADDR;
   logic [1:0]  I_IFIFO_HTRANS;
   logic [2:0]  I_IFIFO_HSIZE;
   logic        I_IFIFO_HWRITE;
   logic        I_IFIFO_HREADY;
   logic        I_IFIFO_CLEAR;
   logic        I_IFIFO_POP;
   logic [31:0] O_IFIFO_DATA;
   logic        O_IFIFO_EMPTY;
   logic        O_IFIFO_FULL;
   logic        O_IFIFO_AFULL;
   logic [5:0]  O_IFIFO_COUNT;
   logic        O_IFIFO_OVERFLOW;

   modport master (
      output I_IFIFO_HRDATA, I_IFIFO_HADDR, I_IFIFO_HTRANS, I_IFIFO_HSIZE,
             I_IFIFO_HWRITE, I_IFIFO_HREADY, I_IFIFO_CLEAR, I_IFIFO_POP,
      input  O_IFIFO_DATA, O_IFIFO_EMPTY, O_IFIFO_FULL, O_IFIFO_AFULL,
             O_IFIFO_COUNT, O_IFIFO_OVERFLOW
   );

   modport slave (
      input  I_IFIFO_HRDATA, I_IFIFO_HADDR, I_IFIFO_HTRANS, I_IFIFO_HSIZE,
             I_IFIFO_HWRITE, I_IFIFO_HREADY, I_IFIFO_CLEAR, I_IFIFO_POP,
      output O_IFIFO_DATA, O_IFIFO_EMPTY, O_IFIFO_FULL, O_IFIFO_AFULL,
             O_IFIFO_COUNT, O_IFIFO_OVERFLOW
   );

endinterface

// File: rtl/ififo_mem.sv
// rtl/ififo_mem.sv - ififo storage: register array, synchronous write, asynchronous read
module ififo_mem #(
   parameter int P_DEPTH = 16,
   parameter int P_AW    = 4
) (
   input  logic            clk,
   input  logic            we,
   input  logic [P_AW-1:0] waddr,
   input  logic [31:0]     wdata,
   input  logic [P_AW-1:0] raddr,
   output logic [31:0]     rdata
);

   logic [31:0] mem [P_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ififo.sv
// rtl/ififo.sv - captures AHB read data phases into a first-word-fall-through FIFO for the core
module ififo
   import ififo_pkg::*;
#(
   parameter int P_DEPTH = 16,
   parameter int P_AFULL = 12
) (
   input logic   I_IFIFO_HCLK,
   input logic   I_IFIFO_HRESET,
   ififo_if.slave bus
);

   localparam int         LP_AW    = $clog2(P_DEPTH);
   localparam logic [5:0] LP_DEPTH = 6'(P_DEPTH);
   localparam logic [5:0] LP_AFULL = 6'(P_AFULL);

   logic             dphase_vld;
   logic [1:0]       dphase_lane;
   logic [2:0]       dphase_size;
   logic [LP_AW-1:0] wr_ptr;
   logic [LP_AW-1:0] rd_ptr;
   logic [5:0]       count;
   logic             overflow;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop_ok;
   logic             push_ok;
   logic [31:0]      push_data;
   logic [31:0]      head_data;
   logic             unused_bits;

   assign unused_bits = ^{bus.I_IFIFO_HADDR[31:2], bus.I_IFIFO_HTRANS[0]};

   assign empty   = (count == 6'd0);
   assign full    = (count == LP_DEPTH);
   assign push    = dphase_vld & bus.I_IFIFO_HREADY;
   assign pop_ok  = bus.I_IFIFO_POP & ~empty;
   // a pop frees a slot in the same edge, so a push into a full FIFO survives
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      push_data = bus.I_IFIFO_HRDATA;
      case (dphase_size)
         HSIZE_BYTE: push_data = {24'h0, bus.I_IFIFO_HRDATA[{dphase_lane, 3'b000} +: 8]};
         HSIZE_HALF: push_data = {16'h0, dphase_lane[1] ? bus.I_IFIFO_HRDATA[31:16]
                                                        : bus.I_IFIFO_HRDATA[15:0]};
         default:    push_data = bus.I_IFIFO_HRDATA;
      endcase
   end

   always_ff @(posedge I_IFIFO_HCLK) begin
      if (I_IFIFO_HRESET || bus.I_IFIFO_CLEAR) begin
         dphase_vld <= 1'b0;
      end else if (bus.I_IFIFO_HREADY) begin
         dphase_vld <= bus.I_IFIFO_HTRANS[1] & ~bus.I_IFIFO_HWRITE;
      end
      if (bus.I_IFIFO_HREADY) begin
         dphase_lane <= bus.I_IFIFO_HADDR[1:0];
         dphase_size <= bus.I_IFIFO_HSIZE;
      end
   end

   always_ff @(posedge I_IFIFO_HCLK) begin
      if (I_IFIFO_HRESET || bus.I_IFIFO_CLEAR) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= 6'd0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + LP_AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + LP_AW'(1);
         end
         count <= count + 6'(push_ok) - 6'(pop_ok);
         if (push & ~push_ok) begin
            overflow <= 1'b1;
         end
      end
   end

   ififo_mem #(
      .P_DEPTH (P_DEPTH),
      .P_AW    (LP_AW)
   ) u_mem (
      .clk   (I_IFIFO_HCLK),
      .we    (push_ok & ~I_IFIFO_HRESET & ~bus.I_IFIFO_CLEAR),
      .waddr (wr_ptr),
      .wdata (push_data),
      .raddr (rd_ptr),
      .rdata (head_data)
   );

   assign bus.O_IFIFO_DATA     = empty ? 32'h0 : head_data;
   assign bus.O_IFIFO_EMPTY    = empty;
   assign bus.O_IFIFO_FULL     = full;
   assign bus.O_IFIFO_AFULL    = (count >= LP_AFULL);
   assign bus.O_IFIFO_COUNT    = count;
   assign bus.O_IFIFO_OVERFLOW = overflow;

endmodule

// File: tb/tb_ififo.sv
// tb/tb_ififo.sv - directed and randomized self-checking bench for ififo against a queue model
module tb_ififo;
   import ififo_pkg::*;

   localparam int DEPTH = 16;
   localparam int AFULL = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic [31:0] q[$];
   logic        m_pend = 1'b0;
   logic [31:0] m_addr = '0;
   logic [2:0]  m_size = '0;
   logic        m_ovf  = 1'b0;

   ififo_if bus ();

   ififo #(.P_DEPTH(DEPTH), .P_AFULL(AFULL)) dut (
      .I_IFIFO_HCLK   (clk),
      .I_IFIFO_HRESET (rst),
      .bus            (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] extract(input logic [31:0] d, input logic [31:0] a,
                                           input logic [2:0] s);
      if (s == 3'd0) return (d >> (8 * (a % 4))) & 32'hFF;
      if (s == 3'd1) return (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      return d;
   endfunction

   // model: a read whose address was accepted completes at the next edge with HREADY high
   task automatic model_edge();
      logic do_pop;
      if (rst || bus.I_IFIFO_CLEAR) begin
         q.delete();
         m_pend = 1'b0;
         m_ovf  = 1'b0;
         return;
      end
      do_pop = bus.I_IFIFO_POP && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (bus.I_IFIFO_HREADY && m_pend) begin
         if (q.size() < DEPTH) q.push_back(extract(bus.I_IFIFO_HRDATA, m_addr, m_size));
         else m_ovf = 1'b1;
      end
      if (bus.I_IFIFO_HREADY) begin
         m_pend = bus.I_IFIFO_HTRANS[1] && !bus.I_IFIFO_HWRITE;
         m_addr = bus.I_IFIFO_HADDR;
         m_size = bus.I_IFIFO_HSIZE;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      chk("count", 32'(bus.O_IFIFO_COUNT), 32'(q.size()));
      chk("empty", 32'(bus.O_IFIFO_EMPTY), 32'(q.size() == 0));
      chk("full",  32'(bus.O_IFIFO_FULL),  32'(q.size() == DEPTH));
      chk("afull", 32'(bus.O_IFIFO_AFULL), 32'(q.size() >= AFULL));
      chk("data",  bus.O_IFIFO_DATA, (q.size() > 0) ? q[0] : 32'h0);
      chk("ovf",   32'(bus.O_IFIFO_OVERFLOW), 32'(m_ovf));
   endtask

   task automatic drive(input logic [1:0] tr, input logic [31:0] ad, input logic [2:0] sz,
                        input logic wr, input logic [31:0] rd, input logic rdy,
                        input logic pp, input logic cl, input logic rs);
      bus.I_IFIFO_HTRANS = tr;
      bus.I_IFIFO_HADDR  = ad;
      bus.I_IFIFO_HSIZE  = sz;
      bus.I_IFIFO_HWRITE = wr;
      bus.I_IFIFO_HRDATA = rd;
      bus.I_IFIFO_HREADY = rdy;
      bus.I_IFIFO_POP    = pp;
      bus.I_IFIFO_CLEAR  = cl;
      rst                = rs;
      cycle();
   endtask

   task automatic idle(input logic pp, input logic cl);
      drive(HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'h0, 1'b1, pp, cl, 1'b0);
   endtask

   // n back-to-back word reads; data phase k returns base+k
   task automatic fill(input int n, input logic [31:0] base, input logic pop_last);
      for (int k = 0; k <= n; k++) begin
         drive((k < n) ? HTRANS_NSEQ : HTRANS_IDLE, 32'(4 * k), HSIZE_WORD, 1'b0,
               base + 32'(k) - 32'd1, 1'b1, (k == n) && pop_last, 1'b0, 1'b0);
      end
   endtask

   initial begin
      drive(HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(HTRANS_NSEQ, 32'h0, HSIZE_WORD, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("rst_count", 32'(bus.O_IFIFO_COUNT), 32'd0);
      chk("rst_empty", 32'(bus.O_IFIFO_EMPTY), 32'd1);
      chk("rst_full",  32'(bus.O_IFIFO_FULL),  32'd0);
      chk("rst_afull", 32'(bus.O_IFIFO_AFULL), 32'd0);
      chk("rst_data",  bus.O_IFIFO_DATA, 32'h0);
      idle(1'b0, 1'b0);
      chk("rst_nopush", 32'(bus.O_IFIFO_COUNT), 32'd0);

      drive(HTRANS_NSEQ, 32'h100, HSIZE_WORD, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0);
      drive(HTRANS_SEQ,  32'h104, HSIZE_WORD, 1'b0, 32'hA0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(HTRANS_SEQ,  32'h108, HSIZE_WORD, 1'b0, 32'hA1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(HTRANS_SEQ,  32'h10C, HSIZE_WORD, 1'b0, 32'hA2, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(HTRANS_IDLE, 32'h0,   HSIZE_WORD, 1'b0, 32'hA3, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("incr4_count", 32'(bus.O_IFIFO_COUNT), 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk("incr4_pop", bus.O_IFIFO_DATA, 32'hA0 + 32'(k));
         idle(1'b1, 1'b0);
      end
      chk("incr4_empty", 32'(bus.O_IFIFO_EMPTY), 32'd1);

      drive(HTRANS_NSEQ, 32'h103, HSIZE_BYTE, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0);
      drive(HTRANS_NSEQ, 32'h102, HSIZE_HALF, 1'b0, 32'hDDCCBBAA, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(HTRANS_IDLE, 32'h0,   HSIZE_WORD, 1'b0, 32'hDDCCBBAA, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("byte_lane3", bus.O_IFIFO_DATA, 32'h0000_00DD);
      idle(1'b1, 1'b0);
      chk("half_lane2", bus.O_IFIFO_DATA, 32'h0000_DDCC);
      idle(1'b1, 1'b0);

      drive(HTRANS_NSEQ, 32'h200, HSIZE_WORD, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(HTRANS_SEQ, 32'h204, HSIZE_WORD, 1'b0, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0);
         chk("stall_nopush", 32'(bus.O_IFIFO_COUNT), 32'd0);
      end
      drive(HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("stall_one", 32'(bus.O_IFIFO_COUNT), 32'd1);
      chk("stall_data", bus.O_IFIFO_DATA, 32'h1234_5678);
      idle(1'b1, 1'b0);

      fill(17, 32'h1000, 1'b0);
      chk("ovf_count", 32'(bus.O_IFIFO_COUNT), 32'd16);
      chk("ovf_full",  32'(bus.O_IFIFO_FULL),  32'd1);
      chk("ovf_flag",  32'(bus.O_IFIFO_OVERFLOW), 32'd1);
      chk("ovf_head",  bus.O_IFIFO_DATA, 32'h1000);
      for (int k = 0; k < 9; k++) idle(1'b1, 1'b0);
      chk("ovf_sticky", 32'(bus.O_IFIFO_OVERFLOW), 32'd1);
      drive(HTRANS_NSEQ, 32'h0, HSIZE_WORD, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("clr_count", 32'(bus.O_IFIFO_COUNT), 32'd0);
      chk("clr_empty", 32'(bus.O_IFIFO_EMPTY), 32'd1);
      chk("clr_ovf",   32'(bus.O_IFIFO_OVERFLOW), 32'd0);

      fill(17, 32'h2000, 1'b1);
      chk("fullpop_count", 32'(bus.O_IFIFO_COUNT), 32'd16);
      chk("fullpop_ovf",   32'(bus.O_IFIFO_OVERFLOW), 32'd0);
      chk("fullpop_head",  bus.O_IFIFO_DATA, 32'h2001);
      idle(1'b0, 1'b1);

      drive(HTRANS_NSEQ, 32'h0, HSIZE_WORD, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("emptypp_count", 32'(bus.O_IFIFO_COUNT), 32'd1);
      chk("emptypp_data",  bus.O_IFIFO_DATA, 32'h5A5A5A5A);
      idle(1'b1, 1'b0);

      drive(HTRANS_NSEQ, 32'h0, HSIZE_WORD, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(HTRANS_SEQ,  32'h4, HSIZE_WORD, 1'b0, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(HTRANS_SEQ,  32'h8, HSIZE_WORD, 1'b0, 32'h2, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'h3, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rstmid_count", 32'(bus.O_IFIFO_COUNT), 32'd0);
      chk("rstmid_empty", 32'(bus.O_IFIFO_EMPTY), 32'd1);
      chk("rstmid_ovf",   32'(bus.O_IFIFO_OVERFLOW), 32'd0);

      for (int ph = 0; ph < 3; ph++) begin
         for (int c = 0; c < 1000; c++) begin
            drive(2'($urandom_range(0, 3)), $urandom, 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) < 1 + 4 * ph), ($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 599) == 0));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
